uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequences the UART receiver: drives its enable, detects each completed byte on the rising edge
//  of its ready flag and pushes that byte into a small FIFO. The FIFO drains to the host through a
//  valid/ready interface.
//  Reports overrun (byte lost because the FIFO was full) and a frame count.
//  Sits between the serial receiver and the bus/host logic of the bring-up design.
// PARAMETERS
//  DEPTH   4   FIFO entries, power of two, >=2
//  CNT_W   8   width of frame counter (wraps)
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  rst_n      in   1      asynchronous active-low reset
//  enable     in   1      host request to receive; 0 = receiver held disabled
//  rx_en      out  1      to receiver en
//  rx_rdy     in   1      from receiver rdy (high after 8th data bit, low on next start bit)
//  rx_data    in   8      from receiver data, valid while rx_rdy=1
//  out_valid  out  1      FIFO non-empty
//  out_data   out  8      FIFO head byte (registered, valid with out_valid)
//  out_ready  in   1      host pop; pop when out_valid & out_ready
//  level      out  $clog2(DEPTH)+1  current FIFO occupancy
//  overrun    out  1      sticky: byte dropped while full
//  ovr_clr    in   1      clears overrun (1-cycle pulse)
//  frames     out  CNT_W  bytes received (accepted or dropped), wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; rx_en=0, out_valid=0, out_data=0, level=0, overrun=0,
//   frames=0. FIFO pointers cleared.
//  FSM states:
//   IDLE: rx_en=0. If enable=1 -> ARM.
//   ARM: rx_en=1. Wait until rx_rdy=0, so a stale ready left from before the disable is not
//    counted -> WAIT.
//   WAIT: rx_en=1. rx_rdy 0->1 edge (rdy_q=0, rx_rdy=1) -> capture rx_data that cycle -> HOLD.
//   HOLD: rx_en=1. rx_rdy=0 -> WAIT.
//  enable=0 in any non-IDLE state -> IDLE next cycle; rx_en drops the same edge. A partial byte is
//   abandoned. FIFO contents, overrun and frames are kept.
//  rx_en is registered: it goes high 1 cycle after enable is seen.
//  Capture rules: exactly one push per rdy rising edge. frames increments on every capture.
//   - FIFO not full: push.
//   - FIFO full and pop in same cycle: push and pop both happen; level unchanged; no overrun.
//   - FIFO full, no pop: byte dropped; overrun set.
//  Latency: captured byte appears at out_valid/out_data 1 cycle after the capture edge when the FIFO
//   was empty (first-word fall-through, registered).
//  Pop when empty is ignored. Simultaneous push+pop when empty: push wins, level=1.
//  Pointers wrap modulo DEPTH. Full is detected with an extra MSB; level = wr_ptr - rd_ptr.
//  overrun: set has priority over ovr_clr in the same cycle.
//  frames wraps from 2^CNT_W-1 to 0 with no flag.
//  out_data holds its last value when out_valid=0; the bench checks it only while valid.
// STRUCTURE
//  Package uart_pkg: localparams for the FSM state encoding (IDLE/ARM/WAIT/HOLD, 2 bits) and
//   UART_DATA_W=8.
//  Sub-module sync_fifo (DEPTH, WIDTH=8): push/pop/full/empty/level.
//  The controller holds the FSM, the rdy edge register, overrun and the frame counter.
//  The receiver is not instantiated here; the top level connects rx_en/rx_rdy/rx_data.
// TESTING  (bench instantiates receiver + uart_rx_ctrl, 1 serial bit per clk)
//  1. Reset: with rst_n=0 mid-run, all outputs return to 0 immediately, without waiting for a clock
//     edge.
//  2. enable=0, toggle rx for 40 clks -> rx_en=0, out_valid=0, frames=0.
//  3. enable=1, send start + 8'b00011100 -> one cycle after rdy rises: out_valid=1,
//     out_data=8'h1C, level=1, frames=1. Then pop -> out_valid=0.
//  4. Send 5 bytes 8'h01..8'h05 with out_ready=0, DEPTH=4 -> level=4, overrun=1, frames=5.
//     Pops yield 01,02,03,04. ovr_clr -> overrun=0.
//  5. Hold rdy high for 3 cycles -> exactly one push. Drop enable then re-enable while rdy is still
//     high -> no extra push.
//  6. FIFO full: capture 8'hAA in the same cycle as a pop -> level stays 4, overrun=0, AA is last.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding and data width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Receive sequencer state encoding (2 bits)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ARM  = ST_ARM,
    S_WAIT = ST_WAIT,
    S_HOLD = ST_HOLD
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered first-word-fall-through head output.
// Pointers carry an extra MSB so full and empty are distinguishable; level = wr - rd.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = dout_q;

  // A pop of an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointers and next head value; the head comes from din when the slot being written
  // this cycle is the one that becomes the head (empty FIFO, or a single entry being popped).
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    dout_d   = dout_q;
    if (wr_ptr_d != rd_ptr_d) begin
      if (do_push && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
        dout_d = din;
      end else begin
        dout_d = mem[rd_ptr_d[AW-1:0]];
      end
    end
  end

  // Storage array, written on accepted pushes only (no reset so it maps to RAM).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Pointer and head-register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enables the receiver, captures one byte per rising edge of its
// ready flag into a FIFO drained by the host, and tracks overrun and a frame counter.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  output logic                     rx_en,
  input  logic                     rx_rdy,
  input  logic [UART_DATA_W-1:0]   rx_data,
  output logic                     out_valid,
  output logic [UART_DATA_W-1:0]   out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  input  logic                     ovr_clr,
  output logic [CNT_W-1:0]         frames
);

  rx_state_e        state_q, state_d;
  logic             rx_en_q;
  logic             rdy_q;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             capture;
  logic             fifo_full, fifo_empty;
  logic             drop;

  // Next-state logic and capture strobe; dropping enable abandons any byte in progress.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: if (enable) state_d = S_ARM;
      // Ignore a ready flag left over from before the receiver was (re)enabled.
      S_ARM:  if (!rx_rdy) state_d = S_WAIT;
      S_WAIT: begin
        if (rx_rdy && !rdy_q) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: if (!rx_rdy) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
    if (!enable) begin
      state_d = S_IDLE;
      capture = 1'b0;
    end
  end

  // A full FIFO with no simultaneous pop loses the captured byte.
  assign drop = capture && fifo_full && !out_ready;

  // Overrun (set wins over clear) and wrapping frame counter.
  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    frames_d = capture ? frames_q + 1'b1 : frames_q;
  end

  // State, registered receiver enable, ready edge register and status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rx_en_q   <= 1'b0;
      rdy_q     <= 1'b0;
      overrun_q <= 1'b0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      rx_en_q   <= (state_d != S_IDLE);
      rdy_q     <= rx_rdy;
      overrun_q <= overrun_d;
      frames_q  <= frames_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capture),
    .din   (rx_data),
    .pop   (out_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level),
    .dout  (out_data)
  );

  assign rx_en     = rx_en_q;
  assign out_valid = !fifo_empty;
  assign overrun   = overrun_q;
  assign frames    = frames_q;

endmodule
